// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Optional HALT state is present only when MC_CTRL_HALT_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_EXEC,
    ST_RWB,
    ST_BRANCH,
    ST_JUMP,
    ST_IEXEC,
    ST_IWB
`ifdef MC_CTRL_HALT_EN
    ,
    ST_HALT
`endif
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h1;
  localparam logic [3:0] OP_SW    = 4'h2;
  localparam logic [3:0] OP_BEQ   = 4'h3;
  localparam logic [3:0] OP_J     = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
`ifdef MC_CTRL_HALT_EN
  localparam logic [3:0] OP_HALT  = 4'hF;
`endif

  // 2'b10 and 2'b11 both select Instruction[7:0]; 11 marks the branch-target use.
  localparam logic [1:0] SELB_RD2    = 2'b00;
  localparam logic [1:0] SELB_ONE    = 2'b01;
  localparam logic [1:0] SELB_IMM    = 2'b10;
  localparam logic [1:0] SELB_BRANCH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return s inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait counter: clear has priority over enable; expire flags the limit.
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 8-bit datapath feeding mAlu.
// Define MC_CTRL_HALT_EN to build the HALT state (opcode 1111).
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       ALUSelA,
  output logic [1:0] ALUSelB,
  output logic [1:0] ALUOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic       PCEn,
  output logic       MemErr,
  output logic       Halted
);

  state_e state, next_state;
  logic   mem_wait, timeout, expire;
  logic   pc_write, pc_write_cond;

  // A memory state counts only the cycles it is stalled; any other cycle restarts the count.
  assign mem_wait = is_mem_state(state) && !MemReady;
  assign timeout  = mem_wait && expire;

  mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!mem_wait || timeout),
    .enable (mem_wait),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (MemReady) next_state = ST_DECODE;
      ST_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
          OP_ADDI:      next_state = ST_IEXEC;
`ifdef MC_CTRL_HALT_EN
          OP_HALT:      next_state = ST_HALT;
`endif
          default:      next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: next_state = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (MemReady)     next_state = ST_MEMWB;
        else if (timeout) next_state = ST_FETCH;
      end
      ST_MEMWR:  if (MemReady || timeout) next_state = ST_FETCH;
      ST_EXEC:   next_state = ST_RWB;
      ST_IEXEC:  next_state = ST_IWB;
`ifdef MC_CTRL_HALT_EN
      ST_HALT:   next_state = ST_HALT;
`endif
      default:   next_state = ST_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  // Gating on rst_n drops all strobes asynchronously while reset is held.
  always_comb begin
    ALUSelA       = 1'b0;
    ALUSelB       = SELB_RD2;
    ALUOp         = ALUOP_ADD;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    PCSource      = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
`ifdef MC_CTRL_HALT_EN
    Halted        = 1'b0;
`endif
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          MemRead  = 1'b1;
          ALUSelB  = SELB_ONE;
          IRWrite  = MemReady;
          pc_write = MemReady;
        end
        ST_DECODE: ALUSelB = SELB_BRANCH;
        ST_MEMADR: begin
          ALUSelA = 1'b1;
          ALUSelB = SELB_IMM;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXEC: begin
          ALUSelA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        ST_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_BRANCH: begin
          ALUSelA       = 1'b1;
          ALUOp         = ALUOP_SUB;
          pc_write_cond = 1'b1;
          PCSource      = PCSRC_ALUOUT;
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        ST_IEXEC: begin
          ALUSelA = 1'b1;
          ALUSelB = SELB_IMM;
        end
        ST_IWB: RegWrite = 1'b1;
`ifdef MC_CTRL_HALT_EN
        ST_HALT: Halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign PCEn   = pc_write | (pc_write_cond & Zero);
  assign MemErr = rst_n & timeout;

`ifndef MC_CTRL_HALT_EN
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table plus reset corner sequences.
module tb_mc_ctrl_fsm;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero, mem_ready;
  logic       alu_sel_a, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       pc_en, mem_err, halted;
  logic [1:0] alu_sel_b, alu_op, pc_source;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Opcode   (opcode),
    .Zero     (zero),
    .MemReady (mem_ready),
    .ALUSelA  (alu_sel_a),
    .ALUSelB  (alu_sel_b),
    .ALUOp    (alu_op),
    .IorD     (iord),
    .MemRead  (mem_read),
    .MemWrite (mem_write),
    .IRWrite  (ir_write),
    .RegWrite (reg_write),
    .RegDst   (reg_dst),
    .MemtoReg (mem_to_reg),
    .PCSource (pc_source),
    .PCEn     (pc_en),
    .MemErr   (mem_err),
    .Halted   (halted)
  );

  typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXEC,
                T_RWB, T_BRANCH, T_JUMP, T_IEXEC, T_IWB, T_HALT} tag_e;

  typedef struct packed {
    logic       sel_a;
    logic [1:0] sel_b;
    logic [1:0] alu_op;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_en, mem_err, halted;
  } out_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       mr;
    tag_e       tag;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  out_t act;
  int   total = 0;
  int   bad   = 0;

  assign act = {alu_sel_a, alu_sel_b, alu_op, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, pc_source, pc_en, mem_err, halted};

  // Expected outputs per state, written out from the control table.
  function automatic out_t expect_out(tag_e t, logic mr, logic z, logic err);
    out_t o = '0;
    case (t)
      T_FETCH:  begin o.mem_read = 1; o.sel_b = 2'b01; o.ir_write = mr; o.pc_en = mr; o.mem_err = err; end
      T_DECODE: o.sel_b = 2'b11;
      T_MEMADR: begin o.sel_a = 1; o.sel_b = 2'b10; end
      T_MEMRD:  begin o.mem_read = 1; o.iord = 1; o.mem_err = err; end
      T_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      T_MEMWR:  begin o.mem_write = 1; o.iord = 1; o.mem_err = err; end
      T_EXEC:   begin o.sel_a = 1; o.alu_op = 2'b10; end
      T_RWB:    begin o.reg_write = 1; o.reg_dst = 1; end
      T_BRANCH: begin o.sel_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
      T_JUMP:   begin o.pc_en = 1; o.pc_src = 2'b10; end
      T_IEXEC:  begin o.sel_a = 1; o.sel_b = 2'b10; end
      T_IWB:    o.reg_write = 1;
      T_HALT:   o.halted = 1;
      default:  ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic void add(input logic [3:0] op, input logic z, input logic mr,
                              input tag_e tag, input logic err = 1'b0);
    vecs.push_back('{op, z, mr, tag, err});
  endfunction

  function automatic void add_n(input int n, input logic [3:0] op, input logic mr, input tag_e tag);
    for (int i = 0; i < n; i++) add(op, 1'b0, mr, tag);
  endfunction

  // Called at posedge+1: drive, queue the expectation, compare at the falling edge.
  task automatic run_vec(input vec_t v, input string name);
    out_t e;
    opcode    = v.op;
    zero      = v.z;
    mem_ready = v.mr;
    exp_q.push_back(expect_out(v.tag, v.mr, v.z, v.err));
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes_low(input string tag);
    check({tag, "_memread"},  32'(mem_read),  32'd0);
    check({tag, "_memwrite"}, 32'(mem_write), 32'd0);
    check({tag, "_irwrite"},  32'(ir_write),  32'd0);
    check({tag, "_regwrite"}, 32'(reg_write), 32'd0);
    check({tag, "_pcen"},     32'(pc_en),     32'd0);
    check({tag, "_memerr"},   32'(mem_err),   32'd0);
    check({tag, "_halted"},   32'(halted),    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 4'h0;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // R-type, zero-wait: FETCH, DECODE, EXEC, RWB, FETCH on cycle 5
    add(4'h0, 0, 1, T_FETCH); add(4'h0, 0, 1, T_DECODE); add(4'h0, 0, 1, T_EXEC); add(4'h0, 0, 1, T_RWB);
    // LW with three stalled MEMRD cycles
    add(4'h1, 0, 1, T_FETCH); add(4'h1, 0, 1, T_DECODE); add(4'h1, 0, 1, T_MEMADR);
    add_n(3, 4'h1, 0, T_MEMRD); add(4'h1, 0, 1, T_MEMRD); add(4'h1, 0, 1, T_MEMWB);
    // SW zero-wait
    add(4'h2, 0, 1, T_FETCH); add(4'h2, 0, 1, T_DECODE); add(4'h2, 0, 1, T_MEMADR); add(4'h2, 0, 1, T_MEMWR);
    // BEQ taken then not taken (Zero high in FETCH must not affect PCEn there)
    add(4'h3, 1, 1, T_FETCH); add(4'h3, 1, 1, T_DECODE); add(4'h3, 1, 1, T_BRANCH);
    add(4'h3, 0, 1, T_FETCH); add(4'h3, 0, 1, T_DECODE); add(4'h3, 0, 1, T_BRANCH);
    // J, ADDI, illegal opcode
    add(4'h4, 0, 1, T_FETCH); add(4'h4, 0, 1, T_DECODE); add(4'h4, 0, 1, T_JUMP);
    add(4'h5, 0, 1, T_FETCH); add(4'h5, 0, 1, T_DECODE); add(4'h5, 0, 1, T_IEXEC); add(4'h5, 0, 1, T_IWB);
    add(4'h6, 0, 1, T_FETCH); add(4'h6, 0, 1, T_DECODE);
    // FETCH stalls then completes
    add_n(2, 4'h0, 0, T_FETCH); add(4'h0, 0, 1, T_FETCH); add(4'h0, 0, 1, T_DECODE);
    add(4'h0, 0, 1, T_EXEC); add(4'h0, 0, 1, T_RWB);
    // FETCH stuck: MemErr on the 5th cycle, FETCH re-entered, again on the 10th
    add_n(4, 4'h0, 0, T_FETCH); add(4'h0, 0, 0, T_FETCH, 1);
    add_n(4, 4'h0, 0, T_FETCH); add(4'h0, 0, 0, T_FETCH, 1);
    // LW timeout in MEMRD
    add(4'h1, 0, 1, T_FETCH); add(4'h1, 0, 1, T_DECODE); add(4'h1, 0, 1, T_MEMADR);
    add_n(4, 4'h1, 0, T_MEMRD); add(4'h1, 0, 0, T_MEMRD, 1);
    // LW: MemReady on the limit cycle wins
    add(4'h1, 0, 1, T_FETCH); add(4'h1, 0, 1, T_DECODE); add(4'h1, 0, 1, T_MEMADR);
    add_n(4, 4'h1, 0, T_MEMRD); add(4'h1, 0, 1, T_MEMRD); add(4'h1, 0, 1, T_MEMWB);
    // SW timeout, then SW with two stalls
    add(4'h2, 0, 1, T_FETCH); add(4'h2, 0, 1, T_DECODE); add(4'h2, 0, 1, T_MEMADR);
    add_n(4, 4'h2, 0, T_MEMWR); add(4'h2, 0, 0, T_MEMWR, 1);
    add(4'h2, 0, 1, T_FETCH); add(4'h2, 0, 1, T_DECODE); add(4'h2, 0, 1, T_MEMADR);
    add_n(2, 4'h2, 0, T_MEMWR); add(4'h2, 0, 1, T_MEMWR);
    // Opcode 1111
    add(4'hF, 0, 1, T_FETCH); add(4'hF, 0, 1, T_DECODE);
`ifdef MC_CTRL_HALT_EN
    for (int i = 0; i < 20; i++) add(4'hF, 0, logic'(i % 2), T_HALT);
`else
    add(4'h0, 0, 1, T_FETCH);
`endif

    #3;
    check_strobes_low("reset");

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d_%s", i, vecs[i].tag.name()));

    // Reset pulse from wherever the table left the FSM
    rst_n = 1'b0;
    #2;
    check_strobes_low("reset2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted mid-MEMWR: MemWrite must drop without waiting for a clock
    run_vec('{4'h2, 1'b0, 1'b1, T_FETCH,  1'b0}, "mr_fetch");
    run_vec('{4'h2, 1'b0, 1'b1, T_DECODE, 1'b0}, "mr_decode");
    run_vec('{4'h2, 1'b0, 1'b1, T_MEMADR, 1'b0}, "mr_memadr");
    mem_ready = 1'b0;
    @(negedge clk);
    check("mr_memwrite_before", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_memwrite_drop", 32'(mem_write), 32'd0);
    check("mr_iord_drop",     32'(iord),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec('{4'h0, 1'b0, 1'b1, T_FETCH,  1'b0}, "mr_after_fetch");
    run_vec('{4'h0, 1'b0, 1'b1, T_DECODE, 1'b0}, "mr_after_decode");
    run_vec('{4'h0, 1'b0, 1'b1, T_EXEC,   1'b0}, "mr_after_exec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the 8-bit datapath; sits directly upstream of mAlu.
- Decodes the instruction register opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the ALU selects (ALUSelA, ALUSelB, ALUOp), register-file, memory and PC enables.
- Consumes mAlu's Zero flag for branch resolution.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for MemReady in a memory state before abort; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  4  Instruction[15:12] from instruction register
- Zero  in  1  mAlu Zero flag
- MemReady  in  1  memory access complete this cycle
- ALUSelA  out  1  0=PC, 1=ReadData1
- ALUSelB  out  2  00=ReadData2, 01=const 1, 10/11=Instruction[7:0]
- ALUOp  out  2  00=add, 01=sub, 10=funct decode
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- RegWrite  out  1  register file write enable
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- PCEn  out  1  PCWrite | (PCWriteCond & Zero), computed combinationally
- MemErr  out  1  one-cycle pulse on memory timeout
- Halted  out  1  see optional feature; tied 0 when the feature is compiled out

Behaviour:
- Opcodes:
  - 0000 R-type
  - 0001 LW
  - 0010 SW
  - 0011 BEQ
  - 0100 J
  - 0101 ADDI
  - others illegal
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, IEXEC, IWB, HALT.
- Outputs are Moore, decoded from the registered state. Exception: in FETCH, IRWrite/PCWrite are gated by MemReady.
- Every output not listed for a state is 0.
- Reset (async, rst_n=0): state=FETCH, timeout counter=0; all strobes 0, MemErr=0, Halted=0. The first fetch begins in the first clock after deassertion.
- FETCH:
  - MemRead=1, IorD=0, ALUSelA=0, ALUSelB=01, ALUOp=00, PCSource=00.
  - When MemReady=1: IRWrite=1, PCWrite=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSelA=0, ALUSelB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEMADR
  - R-type -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> IEXEC
  - illegal -> FETCH
- MEMADR: ALUSelA=1, ALUSelB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1; wait for MemReady -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; wait for MemReady -> FETCH.
- EXEC: ALUSelA=1, ALUSelB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH: ALUSelA=1, ALUSelB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- IEXEC: ALUSelA=1, ALUSelB=10, ALUOp=00 -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Timeout counter (8-bit):
  - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle while waiting with MemReady=0.
  - When the count reaches MEM_TIMEOUT with MemReady still 0: MemErr=1 for one cycle, go to FETCH, no IRWrite/PCWrite/RegWrite.
  - MemReady arriving in the same cycle as the limit wins: normal completion, no MemErr.
- Nominal latency with zero-wait memory (MemReady=1 immediately):
  - 3 cycles: BEQ, J
  - 4 cycles: R-type, ADDI, SW
  - 5 cycles: LW
- Reset mid-operation forces FETCH immediately; any pending strobes drop asynchronously.

Optional Feature:
- Macro: MC_CTRL_HALT_EN.
- Defined: opcode 1111 in DECODE -> HALT. HALT drives all strobes 0 and Halted=1, and is left only by reset.
- Undefined: 1111 is illegal (DECODE -> FETCH); no HALT state is built and Halted is tied 0.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants
  - ALUSelB encodings (SELB_RD2, SELB_ONE, SELB_IMM)
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - PCSource encodings
- One sub-module, mc_mem_timer: counter with clear/enable/expire, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset released, MemReady=1, Opcode=0000 -> FETCH (IRWrite=1, PCEn=1, ALUSelB=01), DECODE, EXEC (ALUOp=10, ALUSelA=1), RWB (RegWrite=1, RegDst=1), back to FETCH on cycle 5.
- Opcode=0001, MemReady=0 for 3 cycles in MEMRD, then 1 -> MEMRD held 4 cycles with MemRead=1, IorD=1; then MEMWB with MemtoReg=1, RegWrite=1.
- Opcode=0011: Zero=1 in BRANCH -> PCEn=1, PCSource=01; repeat with Zero=0 -> PCEn=0.
- MEM_TIMEOUT=4, MemReady stuck 0 in FETCH -> MemErr pulses exactly once, on the 5th FETCH cycle; FETCH is re-entered; IRWrite never asserted.
- rst_n pulled low during MEMWR with MemWrite=1 -> MemWrite drops the same cycle; state=FETCH after release.
- With MC_CTRL_HALT_EN, Opcode=1111 -> Halted=1 and stays 1 for 20 cycles despite MemReady toggling. Without the macro -> returns to FETCH after DECODE and Halted=0.
